// File: rtl/rx_buf_ctrl.sv
// rx_buf_ctrl
//   GMII receive buffer controller. Strips preamble/SFD, writes frame bytes
//   into one of two RAM slots, and offers completed frames to a reader in
//   arrival order. Bad, oversized or slot-less frames are dropped and counted.
//
// Ports
//   clock, reset_n          single clock, asynchronous active-low reset
//   rx_dv, rx_data          GMII receive data valid / byte
//   ram_we, ram_waddr,      buffer RAM write port; address is {slot, offset}
//   ram_wdata
//   frm_valid, frm_slot,    offered frame (oldest committed first)
//   frm_len
//   frm_ack                 reader pulse releasing the offered slot
//   drop_cnt                saturating dropped-frame counter
//   busy                    receive FSM is outside IDLE
module rx_buf_ctrl #(
  parameter int unsigned SLOT_AW = 11,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               rx_dv,
  input  logic [7:0]         rx_data,
  output logic               ram_we,
  output logic [SLOT_AW:0]   ram_waddr,
  output logic [7:0]         ram_wdata,
  output logic               frm_valid,
  output logic               frm_slot,
  output logic [SLOT_AW-1:0] frm_len,
  input  logic               frm_ack,
  output logic [15:0]        drop_cnt,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    DROP     = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_wait_idle;   // set by reset: ignore rx until rx_dv drops
  logic [1:0]         r_full;        // committed, not yet acked
  logic               r_slot;        // slot claimed by the frame in DATA
  logic [SLOT_AW-1:0] r_off;

  logic               r_ram_we;
  logic [SLOT_AW:0]   r_ram_waddr;
  logic [7:0]         r_ram_wdata;

  logic               r_frm_valid;
  logic               r_frm_slot;
  logic [SLOT_AW-1:0] r_frm_len;
  logic               r_pend_valid;
  logic               r_pend_slot;
  logic [SLOT_AW-1:0] r_pend_len;

  logic [15:0]        r_drop_cnt;

  logic               w_ack;
  logic [1:0]         w_free;
  logic               w_has_free;
  logic               w_free_slot;
  logic               w_commit;
  logic               w_drop;
  logic               w_at_max;
  logic [1:0]         w_full_nxt;

  always_comb begin
    w_ack      = frm_ack & r_frm_valid;
    // A slot released by this cycle's ack is already claimable by an SFD.
    w_free     = ~r_full;
    if (w_ack) w_free[r_frm_slot] = 1'b1;
    w_has_free  = |w_free;
    w_free_slot = ~w_free[0];
    w_at_max    = (r_off == SLOT_AW'(MAX_LEN));
    w_commit    = (r_state == DATA) && !rx_dv && (r_off != '0);
    w_drop      = ((r_state == DATA) && !rx_dv && (r_off == '0)) ||
                  ((r_state == DROP) && !rx_dv);
    w_full_nxt  = r_full;
    if (w_ack)    w_full_nxt[r_frm_slot] = 1'b0;
    if (w_commit) w_full_nxt[r_slot]     = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_wait_idle  <= 1'b1;
      r_full       <= '0;
      r_slot       <= 1'b0;
      r_off        <= '0;
      r_ram_we     <= 1'b0;
      r_ram_waddr  <= '0;
      r_ram_wdata  <= '0;
      r_frm_valid  <= 1'b0;
      r_frm_slot   <= 1'b0;
      r_frm_len    <= '0;
      r_pend_valid <= 1'b0;
      r_pend_slot  <= 1'b0;
      r_pend_len   <= '0;
      r_drop_cnt   <= '0;
    end else begin
      r_ram_we <= 1'b0;
      r_full   <= w_full_nxt;

      case (r_state)
        IDLE: begin
          if (r_wait_idle) begin
            if (!rx_dv) r_wait_idle <= 1'b0;
          end else if (rx_dv) begin
            r_state <= (rx_data == 8'h55) ? PREAMBLE : DROP;
          end
        end
        PREAMBLE: begin
          if (!rx_dv) begin
            r_state <= IDLE;
          end else if (rx_data == 8'h55) begin
            r_state <= PREAMBLE;
          end else if (rx_data == 8'hD5 && w_has_free) begin
            r_state <= DATA;
            r_slot  <= w_free_slot;
            r_off   <= '0;
          end else begin
            r_state <= DROP;
          end
        end
        DATA: begin
          if (!rx_dv) begin
            r_state <= IDLE;
          end else if (w_at_max) begin
            // Oversize: slot is released simply by never committing it.
            r_state <= DROP;
          end else begin
            r_ram_we    <= 1'b1;
            r_ram_waddr <= {r_slot, r_off};
            r_ram_wdata <= rx_data;
            r_off       <= r_off + SLOT_AW'(1);
          end
        end
        DROP: begin
          if (!rx_dv) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      if (w_drop && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 16'd1;

      // Two-entry offer queue: head drives the frm_* outputs, pend holds the
      // younger frame. With only two slots, a commit never meets a full queue.
      if (!r_frm_valid) begin
        if (w_commit) begin
          r_frm_valid <= 1'b1;
          r_frm_slot  <= r_slot;
          r_frm_len   <= r_off;
        end
      end else if (w_ack) begin
        if (r_pend_valid) begin
          r_frm_slot   <= r_pend_slot;
          r_frm_len    <= r_pend_len;
          r_pend_valid <= 1'b0;
        end else if (w_commit) begin
          r_frm_slot <= r_slot;
          r_frm_len  <= r_off;
        end else begin
          r_frm_valid <= 1'b0;
        end
      end else if (w_commit) begin
        r_pend_valid <= 1'b1;
        r_pend_slot  <= r_slot;
        r_pend_len   <= r_off;
      end
    end
  end

  assign ram_we    = r_ram_we;
  assign ram_waddr = r_ram_waddr;
  assign ram_wdata = r_ram_wdata;
  assign frm_valid = r_frm_valid;
  assign frm_slot  = r_frm_slot;
  assign frm_len   = r_frm_len;
  assign drop_cnt  = r_drop_cnt;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_rx_buf_ctrl.sv
// tb_rx_buf_ctrl
//   Directed bench for rx_buf_ctrl: GMII frames are driven on the falling
//   edge, RAM writes are logged just after each rising edge, and results are
//   compared against hand-computed values.
module tb_rx_buf_ctrl;

  logic        clock;
  logic        reset_n;
  logic        rx_dv;
  logic [7:0]  rx_data;
  logic        ram_we;
  logic [11:0] ram_waddr;
  logic [7:0]  ram_wdata;
  logic        frm_valid;
  logic        frm_slot;
  logic [10:0] frm_len;
  logic        frm_ack;
  logic [15:0] drop_cnt;
  logic        busy;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  logic [11:0] wq_a[$];
  logic [7:0]  wq_d[$];

  rx_buf_ctrl #(.SLOT_AW(11), .MAX_LEN(1518)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .rx_dv     (rx_dv),
    .rx_data   (rx_data),
    .ram_we    (ram_we),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .frm_valid (frm_valid),
    .frm_slot  (frm_slot),
    .frm_len   (frm_len),
    .frm_ack   (frm_ack),
    .drop_cnt  (drop_cnt),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    #1;
    if (ram_we === 1'b1) begin
      wq_a.push_back(ram_waddr);
      wq_d.push_back(ram_wdata);
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input int n, input logic [7:0] first,
                            input bit ack_sfd, input bit ack_end);
    logic [7:0] b;
    for (int i = 0; i < 7; i++) begin
      @(negedge clock); rx_dv = 1'b1; rx_data = 8'h55;
    end
    @(negedge clock); rx_data = 8'hD5; frm_ack = ack_sfd;
    for (int i = 0; i < n; i++) begin
      b = first + 8'(i);
      @(negedge clock); rx_data = b; frm_ack = 1'b0;
    end
    @(negedge clock); rx_dv = 1'b0; rx_data = 8'h00; frm_ack = ack_end;
    @(negedge clock); frm_ack = 1'b0;
  endtask

  task automatic pulse_ack();
    @(negedge clock); frm_ack = 1'b1;
    @(negedge clock); frm_ack = 1'b0;
  endtask

  initial begin
    int unsigned base;
    int unsigned bad;

    reset_n = 1'b0; rx_dv = 1'b0; rx_data = 8'h00; frm_ack = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_we",    32'(ram_we),    0);
    check("rst_waddr", 32'(ram_waddr), 0);
    check("rst_wdata", 32'(ram_wdata), 0);
    check("rst_valid", 32'(frm_valid), 0);
    check("rst_slot",  32'(frm_slot),  0);
    check("rst_len",   32'(frm_len),   0);
    check("rst_drop",  32'(drop_cnt),  0);
    check("rst_busy",  32'(busy),      0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Basic 60-byte frame into slot 0
    base = wq_a.size();
    send_frame(60, 8'h00, 1'b0, 1'b0);
    check("t1_wr_cnt", wq_a.size() - base, 60);
    bad = 0;
    for (int i = 0; i < 60; i++)
      if (wq_a[base + i] !== 12'(i) || wq_d[base + i] !== 8'(i)) bad++;
    check("t1_wr_bad",  bad, 0);
    check("t1_last_a",  32'(wq_a[base + 59]), 32'h03B);
    check("t1_valid",   32'(frm_valid), 1);
    check("t1_slot",    32'(frm_slot),  0);
    check("t1_len",     32'(frm_len),   60);

    // Frame B commits in the same cycle slot 0 is acked
    base = wq_a.size();
    send_frame(64, 8'h40, 1'b0, 1'b1);
    check("t2_first_a", 32'(wq_a[base]), 32'h800);
    check("t2_valid",   32'(frm_valid), 1);
    check("t2_slot",    32'(frm_slot),  1);
    check("t2_len",     32'(frm_len),   64);
    pulse_ack();
    check("t2_empty",   32'(frm_valid), 0);

    // Both slots filled, third frame has nowhere to go
    send_frame(64, 8'h10, 1'b0, 1'b0);
    send_frame(65, 8'h20, 1'b0, 1'b0);
    base = wq_a.size();
    send_frame(30, 8'h30, 1'b0, 1'b0);
    @(negedge clock);
    check("t3_drop_wr", wq_a.size() - base, 0);
    check("t3_drop",    32'(drop_cnt), 1);
    check("t3_slot",    32'(frm_slot), 0);
    check("t3_len",     32'(frm_len),  64);

    // Ack coinciding with the SFD frees slot 0 for this frame
    base = wq_a.size();
    send_frame(20, 8'h60, 1'b1, 1'b0);
    check("t4_wr_cnt",  wq_a.size() - base, 20);
    check("t4_first_a", 32'(wq_a[base]), 32'h000);
    check("t4_slot",    32'(frm_slot), 1);
    check("t4_len",     32'(frm_len),  65);
    pulse_ack();
    check("t4_slot2",   32'(frm_slot), 0);
    check("t4_len2",    32'(frm_len),  20);
    pulse_ack();
    check("t4_empty",   32'(frm_valid), 0);
    pulse_ack();
    check("t4_ign_ack", 32'(frm_valid), 0);

    // Bad preamble: drop counted only after rx_dv falls
    base = wq_a.size();
    @(negedge clock); rx_dv = 1'b1; rx_data = 8'h55;
    @(negedge clock); rx_data = 8'h12;
    @(negedge clock); rx_data = 8'hD5;
    @(negedge clock); rx_data = 8'h01;
    @(negedge clock); rx_data = 8'h02;
    check("t5_drop_hi", 32'(drop_cnt), 1);
    check("t5_busy",    32'(busy),     1);
    @(negedge clock); rx_dv = 1'b0; rx_data = 8'h00;
    @(negedge clock);
    check("t5_drop",    32'(drop_cnt), 2);
    check("t5_idle",    32'(busy),     0);
    check("t5_wr",      wq_a.size() - base, 0);

    // 1519-byte frame: 1518 writes then dropped, slot 0 released
    base = wq_a.size();
    send_frame(1519, 8'h00, 1'b0, 1'b0);
    check("t6_wr_cnt",  wq_a.size() - base, 1518);
    check("t6_last_a",  32'(wq_a[base + 1517]), 32'h5ED);
    check("t6_last_d",  32'(wq_d[base + 1517]), 32'hED);
    check("t6_valid",   32'(frm_valid), 0);
    check("t6_drop",    32'(drop_cnt),  3);
    base = wq_a.size();
    send_frame(10, 8'h70, 1'b0, 1'b0);
    check("t6_reuse_a", 32'(wq_a[base]), 32'h000);
    check("t6_slot",    32'(frm_slot), 0);
    check("t6_len",     32'(frm_len),  10);
    pulse_ack();

    // Reset at byte 30, released while rx_dv is still high
    for (int i = 0; i < 7; i++) begin
      @(negedge clock); rx_dv = 1'b1; rx_data = 8'h55;
    end
    @(negedge clock); rx_data = 8'hD5;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock); rx_data = 8'(i);
    end
    @(negedge clock); reset_n = 1'b0; rx_data = 8'h1E;
    #1;
    check("t7_rst_drop", 32'(drop_cnt), 0);
    check("t7_rst_busy", 32'(busy),     0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1; rx_data = 8'h55;
    base = wq_a.size();
    @(negedge clock); rx_data = 8'h55;
    @(negedge clock); rx_data = 8'h55;
    @(negedge clock); rx_data = 8'hD5;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock); rx_data = 8'h80 + 8'(i);
    end
    @(negedge clock); rx_dv = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clock);
    check("t7_wr",    wq_a.size() - base, 0);
    check("t7_valid", 32'(frm_valid), 0);
    check("t7_drop",  32'(drop_cnt),  0);
    base = wq_a.size();
    send_frame(10, 8'hA0, 1'b0, 1'b0);
    check("t7_first_a", 32'(wq_a[base]), 32'h000);
    check("t7_first_d", 32'(wq_d[base]), 32'hA0);
    check("t7_slot",    32'(frm_slot), 0);
    check("t7_len",     32'(frm_len),  10);
    check("t7_valid2",  32'(frm_valid), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/rx_buf_ctrl.md
RX_BUF_CTRL -- requirements
Module: rx_buf_ctrl

Interface
REQ-001 SHALL have parameter SLOT_AW, default 11: per-slot byte address width (2048-byte slots).
REQ-002 SHALL have parameter MAX_LEN, default 1518: largest accepted frame length in bytes, excluding preamble and SFD.
REQ-003 SHALL have port clock, input, 1: single clock for all logic.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port rx_dv, input, 1: GMII receive data valid, synchronous to clock.
REQ-006 SHALL have port rx_data, input, 8: GMII receive byte.
REQ-007 SHALL have port ram_we, output, 1: buffer RAM write enable.
REQ-008 SHALL have port ram_waddr, output, SLOT_AW+1: write address {slot, offset}.
REQ-009 SHALL have port ram_wdata, output, 8: write data.
REQ-010 SHALL have port frm_valid, output, 1: a completed frame is available to the reader.
REQ-011 SHALL have port frm_slot, output, 1: slot holding the offered frame.
REQ-012 SHALL have port frm_len, output, SLOT_AW: byte length of the offered frame.
REQ-013 SHALL have port frm_ack, input, 1: one-cycle pulse from the reader that releases the offered slot.
REQ-014 SHALL have port drop_cnt, output, 16: count of dropped frames.
REQ-015 SHALL have port busy, output, 1: high while the FSM is in any state other than IDLE.

Function
REQ-016 FSM states SHALL be IDLE, PREAMBLE, DATA and DROP.
REQ-017 In IDLE: rx_dv=1 with rx_data=0x55 SHALL go to PREAMBLE; rx_dv=1 with any other byte SHALL go to DROP.
REQ-018 In PREAMBLE:
- 0x55 SHALL stay in PREAMBLE.
- 0xD5 SHALL go to DATA if a free slot exists, otherwise to DROP.
- Any other byte SHALL go to DROP.
- rx_dv=0 SHALL return to IDLE without counting a drop.
REQ-019 On entry to DATA, the controller SHALL claim the lowest-numbered free slot and clear the write offset to 0.
REQ-020 In DATA, each sampled byte with rx_dv=1 SHALL produce ram_we=1, ram_waddr={slot, offset} and ram_wdata=byte, all registered and visible the cycle after sampling. The offset SHALL then increment.
REQ-021 In DATA, a byte that would make the length exceed MAX_LEN SHALL NOT be written. The FSM SHALL go to DROP and the claimed slot SHALL be freed.
REQ-022 In DATA, rx_dv=0 SHALL end the frame:
- Length 0: free the slot and count a drop.
- Length > 0: commit the slot as full with its length, then go to IDLE.
REQ-023 DROP SHALL ignore data until rx_dv=0, then increment drop_cnt once and return to IDLE.
REQ-024 drop_cnt SHALL saturate at 0xFFFF.
REQ-025 Committed frames SHALL be offered oldest first. frm_valid, frm_slot and frm_len SHALL be registered, stable while frm_valid=1, and updated the cycle after a commit or an ack.
REQ-026 frm_ack while frm_valid=1 SHALL free frm_slot. The next pending frame, if any, SHALL be offered on the following cycle; otherwise frm_valid SHALL drop.
REQ-027 frm_ack while frm_valid=0 SHALL be ignored.
REQ-028 A commit and an ack in the same cycle SHALL both take effect, with no loss of either frame.
REQ-029 A slot freed by an ack in the same cycle as an SFD SHALL be claimable by that SFD.
REQ-030 ram_we SHALL be 0 in every state except on DATA writes.

Reset
REQ-031 While reset_n=0, the controller SHALL hold:
- FSM state IDLE, both slots free, write offset 0.
- ram_we=0, ram_waddr=0, ram_wdata=0.
- frm_valid=0, frm_slot=0, frm_len=0.
- drop_cnt=0, busy=0.
REQ-032 Reset asserted mid-frame SHALL abandon the frame without counting a drop. After reset_n releases, the controller SHALL wait for rx_dv=0 before accepting a new preamble.

Verification
REQ-033 Bench SHALL drive 7x0x55, 0xD5, then 60 bytes 0x00..0x3B, then rx_dv=0 -> exactly 60 writes to addresses 0x000..0x03B with matching data, followed by frm_valid=1, frm_slot=0, frm_len=60.
REQ-034 Bench SHALL send two 64-byte frames with no ack, then a third frame -> the third frame is dropped, drop_cnt=1, and no writes occur after its SFD.
REQ-035 Bench SHALL send a 1519-byte frame -> 1518 writes occur, no commit, drop_cnt increments, and the slot is freed.
REQ-036 Bench SHALL pulse frm_ack in the same cycle that frame 2 commits while frame 1 is offered -> the next cycle shows frm_slot=1 with frame 2's length, and frm_valid stays 1.
REQ-037 Bench SHALL start a frame with 0x55, 0x12 -> DROP, with drop_cnt incremented only after rx_dv falls.
REQ-038 Bench SHALL assert reset_n=0 at byte 30 of a frame and release it while rx_dv=1 -> no commit, drop_cnt=0, and the next clean frame is written to slot 0.
